// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the bit-serial subtractor.
//   state_t        FSM state encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  default operand width in bits
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle of the serial subtractor.
//   start  request to begin a subtraction (master -> slave)
//   A, B   unsigned minuend / subtrahend, WIDTH bits (master -> slave)
//   busy   operation in progress (slave -> master)
//   done   one-cycle pulse, new result on out (slave -> master)
//   out    {borrow, difference}, WIDTH+1 bits (slave -> master)
interface serial_subtractor_if
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   out;

    modport master (output start, A, B, input busy, done, out);
    modport slave  (input start, A, B, output busy, done, out);
endinterface

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit combinational borrow cell.
//   a, b  operand bits (computes a - b - bin)
//   bin   borrow in
//   d     difference bit
//   bout  borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: unsigned A - B computed one bit per clock, LSB first,
// with a single full_subtractor cell.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_subtractor_if slave: start/A/B in, busy/done/out back
// A start seen in IDLE latches the operands; WIDTH SHIFT cycles follow,
// then one DONE cycle with done high; out holds until the next result.
module serial_subtractor
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   diff_sh;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     out_q;
    logic               d_bit;
    logic               bout_bit;
    logic               last_bit;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            out_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh    <= bus.A;
                        b_sh    <= bus.B;
                        diff_sh <= '0;
                        borrow  <= 1'b0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    // New difference bit enters at the MSB so that after
                    // WIDTH shifts bit 0 sits at the LSB.
                    diff_sh <= {d_bit, diff_sh[WIDTH-1:1]};
                    borrow  <= bout_bit;
                    if (last_bit) begin
                        // Final bit is taken straight from the cell since
                        // diff_sh has not yet absorbed it.
                        out_q <= {bout_bit, d_bit, diff_sh[WIDTH-1:1]};
                    end else begin
                        // Counter stops at WIDTH-1 and never wraps.
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.out  = out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized self-checking bench for serial_subtractor.
// Expected results come from plain modular arithmetic; expected timing comes
// from the operation's cycle budget (WIDTH busy cycles, then one done cycle).
module tb_serial_subtractor;

    localparam int W       = 4;
    localparam int OUT_MOD = 1 << (W + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_sub(input int a, input int b);
        return 32'((a - b) & (OUT_MOD - 1));
    endfunction

    // One full operation; inputs are scrambled (and start randomly pulsed)
    // while the operation runs to confirm they are ignored.
    task automatic run_op(input int a, input int b, input string tag, output bit ok);
        logic [W:0]  prev_out;
        logic [31:0] exp_out;
        int          busy_cnt;
        int          lat;
        bit          seen;
        bit          leaked;
        exp_out  = ref_sub(a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = W'(a);
        bus.B     = W'(b);
        prev_out  = bus.out;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt  = 0;
        lat       = -1;
        seen      = 1'b0;
        leaked    = 1'b0;
        for (int k = 0; k < 4 * W; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (bus.out !== prev_out) leaked = 1'b1;
            bus.A     = W'($urandom);
            bus.B     = W'($urandom);
            bus.start = 1'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(W));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W));
        chk({tag, " out_held_during_shift"}, 32'(leaked), 32'd0);
        chk({tag, " out"}, 32'(bus.out), exp_out);
        ok = seen && (32'(bus.out) == exp_out);
        @(negedge clk);
        chk({tag, " done_single_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        chk({tag, " out_hold"}, 32'(bus.out), exp_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int ok_cnt;
        int last_done;
        int npulses;
        int busy_run;
        int done_cnt;
        logic [W:0] held;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset out", 32'(bus.out), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_op(9, 3, "9-3", ok);
        chk("9-3 literal", 32'(bus.out), 32'b00110);
        run_op(3, 9, "3-9", ok);
        chk("3-9 literal", 32'(bus.out), 32'b11010);
        run_op(0, 15, "0-15", ok);
        chk("0-15 literal", 32'(bus.out), 32'b10001);
        run_op(15, 15, "15-15", ok);
        chk("15-15 literal", 32'(bus.out), 32'd0);

        // Idle with start low: nothing moves
        held = bus.out;
        repeat (3) begin
            @(negedge clk);
            chk("idle busy", 32'(bus.busy), 32'd0);
            chk("idle out", 32'(bus.out), 32'(held));
        end

        // start held high: back-to-back operations, inputs scrambled in SHIFT
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = W'(9);
        bus.B     = W'(3);
        last_done = -1;
        npulses   = 0;
        busy_run  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.busy) busy_run++;
            if (bus.done) begin
                chk("stream out", 32'(bus.out), ref_sub(9, 3));
                chk("stream busy_cycles", 32'(busy_run), 32'(W));
                if (last_done >= 0) chk("stream period", 32'(c - last_done), 32'(W + 2));
                busy_run  = 0;
                last_done = c;
                npulses++;
            end
            if (bus.busy) begin
                bus.A = W'($urandom);
                bus.B = W'($urandom);
            end else begin
                bus.A = W'(9);
                bus.B = W'(3);
            end
        end
        chk("stream pulses", 32'(npulses), 32'd3);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);

        // Reset in the middle of SHIFT
        run_op(12, 5, "12-5", ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = W'(10);
        bus.B     = W'(4);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort out", 32'(bus.out), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        chk("abort no_done", 32'(done_cnt), 32'd0);
        run_op(10, 4, "post_reset 10-4", ok);

        // Random operands
        ok_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, (1 << W) - 1));
            rb = int'($urandom_range(0, (1 << W) - 1));
            run_op(ra, rb, $sformatf("rand%0d %0d-%0d", i, ra, rb), ok);
            if (ok) ok_cnt++;
        end
        $display("random ops: %0d of 16 correct", ok_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
